// File: rtl/led_pulse_hold.sv
// Per-channel pulse-to-level converter for board LEDs: stretch mode holds each LED
// for HOLD_CYCLES after its last pulse, toggle mode flips it with a lockout window.
module led_pulse_hold #(
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2500000,
  parameter int CNT_W       = 22
) (
  input  logic             CLK50MHZ,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] pulse_in,
  input  logic             mode_toggle,
  output logic [WIDTH-1:0] led_out,
  output logic             busy
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  logic             mode_q;
  logic             mode_d;
  logic [WIDTH-1:0] led_d;
  logic [CNT_W-1:0] cnt   [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    mode_d = mode_q;
    led_d  = led_out;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt[i];
    end

    if (mode_toggle != mode_q) begin
      // A mode switch wipes every channel and swallows pulses on that edge.
      mode_d = mode_toggle;
      led_d  = '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!mode_q) begin
          if (pulse_in[i]) begin
            led_d[i] = 1'b1;
            cnt_d[i] = RELOAD;
          end else if (cnt[i] != '0) begin
            cnt_d[i] = cnt[i] - CNT_W'(1);
          end else begin
            led_d[i] = 1'b0;
          end
        end else begin
          if (pulse_in[i] && (cnt[i] == '0)) begin
            led_d[i] = ~led_out[i];
            cnt_d[i] = RELOAD;
          end else if (cnt[i] != '0) begin
            cnt_d[i] = cnt[i] - CNT_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (!RST_N) begin
      mode_q  <= 1'b0;
      led_out <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      mode_q  <= mode_d;
      led_out <= led_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      busy = busy | (cnt[i] != '0);
    end
  end

endmodule
